// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output queue.
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch targets are word addresses; the low two bits are ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular queue of fetched {pc, instr} entries with a synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy tracking; clear wins over a simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: one-cycle memory, epoch-tagged in-flight request, output queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_inflight_pc;
  logic             r_inflight;
  logic             r_inflight_epoch;
  logic             r_epoch;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_occupancy;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;

  assign if_valid    = (w_count != '0) && !rst;
  assign w_pop       = if_valid && if_ready;
  assign w_occupancy = w_count + {{(CNT_W-1){1'b0}}, r_inflight};

  // A slot is reserved for every in-flight request, so the queue can never overflow.
  assign w_issue = !rst && !redirect &&
                   ((w_occupancy < DEPTH_C) || ((w_occupancy == DEPTH_C) && w_pop));

  assign w_push      = r_inflight && (r_inflight_epoch == r_epoch) && !redirect && !rst;
  assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

  assign imem_rd_en = w_issue;
  assign imem_addr  = r_pc;
  assign if_instr   = w_head.instr;
  assign if_pc      = w_head.pc;

  // PC, in-flight and epoch state; redirect overrides issue and increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
    end else if (redirect) begin
      r_pc       <= align_pc(redirect_pc);
      r_epoch    <= ~r_epoch;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc             <= r_pc + PC_STEP;
        r_inflight_pc    <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed per-cycle stimulus, decoupled transfer monitors.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic        rst1;
  logic        imem_rd_en1;
  logic [31:0] imem_addr1;
  logic [31:0] imem_rdata1;
  logic        if_valid1;
  logic [31:0] if_instr1;
  logic [31:0] if_pc1;
  logic        redirect1 = 1'b0;
  logic [31:0] redirect_pc1 = 32'h0;
  logic        if_ready1 = 1'b1;

  logic        follow_rst1 = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
    .clk(clk), .rst(rst1), .imem_rd_en(imem_rd_en1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .redirect(redirect1), .redirect_pc(redirect_pc1),
    .if_valid(if_valid1), .if_ready(if_ready1), .if_instr(if_instr1), .if_pc(if_pc1)
  );

  // One-cycle instruction memory whose data is the address with a fixed pattern.
  always @(posedge clk) begin
    imem_rdata  <= imem_addr ^ 32'hA5A5_0000;
    imem_rdata1 <= imem_addr1 ^ 32'hA5A5_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every accepted instruction must be the next expected one, in order.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_xfer: got pc %h expected no transfer", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("xfer_pc", if_pc, e);
        chk("xfer_instr", if_instr, e ^ 32'hA5A5_0000);
      end
    end
  end

  always @(negedge clk) begin
    if (if_valid1 === 1'b1 && exp1_q.size() != 0) begin
      logic [31:0] e1;
      e1 = exp1_q.pop_front();
      chk("wrap_pc", if_pc1, e1);
    end
  end

  task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst         = r;
    if_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    if (follow_rst1) rst1 = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18,
              32'h100, 32'h104, 32'h108, 32'h0, 32'h4, 32'h8,
              32'h200, 32'h204, 32'h208, 32'h400, 32'h404,
              32'h0, 32'h4, 32'h8};
    exp1_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c0
    chk("c0_rd_en", {31'h0, imem_rd_en}, 32'h1);
    chk("c0_valid", {31'h0, if_valid}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c1
    chk("c1_valid", {31'h0, if_valid}, 32'h0);
    chk("c1_addr", imem_addr, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c2
    chk("c2_valid", {31'h0, if_valid}, 32'h1);
    for (int i = 3; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Stall: queue fills to DEPTH, head held, no further requests.
    step(1'b0, 1'b0, 1'b0, 32'h0);                                   // c6
    for (int i = 7; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_rd_en", {31'h0, imem_rd_en}, 32'h0);
      chk("stall_pc", if_pc, 32'h10);
      chk("stall_valid", {31'h0, if_valid}, 32'h1);
    end
    for (int i = 11; i <= 13; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect while stalled with a response in flight.
    step(1'b0, 1'b0, 1'b1, 32'h100);                                 // c14
    chk("redir_rd_en", {31'h0, imem_rd_en}, 32'h0);
    for (int i = 15; i <= 18; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);                                   // c19
    for (int i = 20; i <= 23; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with transfer of pc 0x8; unaligned target.
    step(1'b0, 1'b1, 1'b1, 32'h203);                                 // c24
    chk("redir2_rd_en", {31'h0, imem_rd_en}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c25
    chk("align_addr", imem_addr, 32'h200);
    for (int i = 26; i <= 28; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirects: the second target wins.
    step(1'b0, 1'b1, 1'b1, 32'h300);                                 // c29
    step(1'b0, 1'b1, 1'b1, 32'h400);                                 // c30
    chk("b2b_valid", {31'h0, if_valid}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c31
    chk("b2b_addr", imem_addr, 32'h400);
    for (int i = 32; i <= 34; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset mid-stream with two entries queued.
    follow_rst1 = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);                                   // c35
    chk("pre_rst_pc", if_pc, 32'h408);
    step(1'b1, 1'b0, 1'b0, 32'h0);                                   // c36
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);                                   // c37
    chk("post_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_rd_en", {31'h0, imem_rd_en}, 32'h1);
    for (int i = 38; i <= 41; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 42; i <= 44; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    chk("exp_q_drained", exp_q.size(), 32'h0);
    chk("exp1_q_drained", exp1_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
